// File: rtl/ir_sequencer.sv
// ir_sequencer: table-driven IR loader. Each table entry is pushed to the
// datapath IR with a one-cycle IR_Enable pulse. After a programmable gap the
// selected register is optionally compared against an expected value, and
// the outcome is accumulated into pass/fail statistics.
//
// state   | meaning
// S_IDLE  | parked after reset or abort, waiting for start
// S_LOAD  | table[idx] on IR_In, IR_Enable pulses unless hold is high
// S_WAIT  | count down gap cycles while the datapath executes
// S_CHECK | sample rf_data, update statistics, advance or finish
// S_DONE  | run complete, statistics held until the next start
module ir_sequencer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int GAP_W  = 4,
  parameter int REG_W  = 5
) (
  input  logic              Clk,
  input  logic              RESET_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_instr,
  input  logic [DATA_W-1:0] prog_expect,
  input  logic              prog_chk,
  input  logic [REG_W-1:0]  prog_reg,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  input  logic [ADDR_W:0]   len,
  input  logic [GAP_W-1:0]  gap,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] IR_In,
  output logic              IR_Enable,
  output logic [REG_W-1:0]  chk_reg,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pass_cnt,
  output logic [ADDR_W:0]   fail_cnt,
  output logic [ADDR_W-1:0] first_fail,
  output logic              fail_flag
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   STAT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   STAT_MAX = '1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

  logic [DATA_W-1:0] instr_mem  [DEPTH];
  logic [DATA_W-1:0] expect_mem [DEPTH];
  logic              chk_mem    [DEPTH];
  logic [REG_W-1:0]  regsel_mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [GAP_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   pass_q, pass_d;
  logic [ADDR_W:0]   fail_q, fail_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic              ir_en;
  logic [ADDR_W:0]   eff_len;

  assign busy    = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign eff_len = (len < DEPTH_L) ? len : DEPTH_L;

  // Program table: written only while no run is using it; no reset needed.
  always_ff @(posedge Clk) begin
    if (prog_we && !busy && ({1'b0, prog_addr} < DEPTH_L)) begin
      instr_mem[prog_addr]  <= prog_instr;
      expect_mem[prog_addr] <= prog_expect;
      chk_mem[prog_addr]    <= prog_chk;
      regsel_mem[prog_addr] <= prog_reg;
    end
  end

  // Sequencer state and statistics registers.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      first_q <= '0;
      flag_q  <= 1'b0;
      ir_q    <= '0;
      reg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      flag_q  <= flag_d;
      ir_q    <= ir_d;
      reg_q   <= reg_d;
    end
  end

  // Next-state, statistics update and IR strobe.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    first_d = first_q;
    flag_d  = flag_q;
    ir_d    = ir_q;
    reg_d   = reg_q;
    ir_en   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (!abort && start) begin
          idx_d   = '0;
          pass_d  = '0;
          fail_d  = '0;
          first_d = '0;
          flag_d  = 1'b0;
          len_d   = eff_len;
          state_d = (eff_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        // Shadow copies keep IR_In/chk_reg stable once LOAD is left.
        ir_d  = instr_mem[idx_q];
        reg_d = regsel_mem[idx_q];
        if (abort) begin
          state_d = S_IDLE;
        end else if (!hold) begin
          ir_en = 1'b1;
          if (gap == '0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = gap;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == GAP_ONE) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - GAP_ONE;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (chk_mem[idx_q]) begin
            if (rf_data == expect_mem[idx_q]) begin
              if (pass_q != STAT_MAX) pass_d = pass_q + STAT_ONE;
            end else begin
              if (fail_q != STAT_MAX) fail_d = fail_q + STAT_ONE;
              if (!flag_q) begin
                flag_d  = 1'b1;
                first_d = idx_q;
              end
            end
          end
          if ({1'b0, idx_q} == (len_q - STAT_ONE)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign IR_In      = (state_q == S_LOAD) ? instr_mem[idx_q] : ir_q;
  assign chk_reg    = (state_q == S_LOAD) ? regsel_mem[idx_q] : reg_q;
  assign IR_Enable  = ir_en;
  assign done       = (state_q == S_DONE);
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign first_fail = first_q;
  assign fail_flag  = flag_q;

endmodule
